// File: rtl/mips_pkg.sv
// Shared encodings, FSM states and control-word layout for the multicycle MIPS datapath.
package mips_pkg;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] JAL   = 6'h03;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] SLTI  = 6'h0A;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;
  localparam logic [5:0] SLT = 6'h2A;
  localparam logic [5:0] JR  = 6'h08;

  typedef enum logic [2:0] { ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT } alu_op_t;
  typedef enum logic [2:0] { FETCH, DECODE, EXEC, MEM, WB, TRAP } state_t;
  typedef enum logic [1:0] { PC_ALU, PC_JUMP, PC_ALUOUT, PC_A } pc_src_t;
  typedef enum logic [1:0] { B_REG, B_FOUR, B_IMM, B_BRANCH } alu_b_t;
  typedef enum logic [1:0] { DST_RD, DST_RT, DST_RA } rf_dst_t;
  typedef enum logic [1:0] { SRC_ALUOUT, SRC_MDR, SRC_PC } rf_src_t;

  typedef struct packed {
    logic    ir_we;
    logic    pc_we;
    pc_src_t pc_src;
    logic    ab_we;
    logic    aluout_we;
    logic    mdr_we;
    logic    alu_a_pc;
    alu_b_t  alu_b;
    alu_op_t alu_op;
    logic    rf_we;
    rf_dst_t rf_dst;
    rf_src_t rf_src;
    logic    mem_req;
    logic    mem_we;
    logic    mem_addr_aluout;
  } ctrl_t;

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mc_control.sv
// Multicycle controller: state register, instruction decode and the per-state control word.
module mc_control
  import mips_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       PCinit,
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic       a_eq_b,
  input  logic       mem_ack,
  output ctrl_t      ctrl,
  output logic       retire,
  output logic       trap
);

  state_t  state;
  alu_op_t fn_op;
  logic    is_rtype, is_j, is_jal, is_beq, is_slti, is_lw, is_sw, is_jr;
  logic    op_legal, fn_legal, bad;

  assign is_rtype = (op == RTYPE);
  assign is_j     = (op == J);
  assign is_jal   = (op == JAL);
  assign is_beq   = (op == BEQ);
  assign is_slti  = (op == SLTI);
  assign is_lw    = (op == LW);
  assign is_sw    = (op == SW);
  assign is_jr    = is_rtype && (fn == JR);
  assign op_legal = op inside {RTYPE, J, JAL, BEQ, ADDI, SLTI, LW, SW};
  assign fn_legal = fn inside {ADD, SUB, AND, OR, SLT, JR};
  // Unknown opcodes are caught in DECODE, unknown functs only once EXEC sees an R-type.
  assign bad = ((state == DECODE) && !op_legal) ||
               ((state == EXEC) && is_rtype && !fn_legal);

  always_comb begin
    case (fn)
      SUB:     fn_op = ALU_SUB;
      AND:     fn_op = ALU_AND;
      OR:      fn_op = ALU_OR;
      SLT:     fn_op = ALU_SLT;
      default: fn_op = ALU_ADD;
    endcase
  end

  // NOTE: every field gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    ctrl = '0;
    if (!PCinit) begin
      case (state)
        FETCH: begin
          ctrl.mem_req  = 1'b1;
          ctrl.alu_a_pc = 1'b1;
          ctrl.alu_b    = B_FOUR;
          ctrl.ir_we    = mem_ack;
          ctrl.pc_we    = mem_ack;
          ctrl.pc_src   = PC_ALU;
        end
        DECODE: begin
          ctrl.ab_we     = 1'b1;
          ctrl.aluout_we = 1'b1;
          ctrl.alu_a_pc  = 1'b1;
          ctrl.alu_b     = B_BRANCH;
          if (is_j || is_jal) begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_JUMP;
          end
          if (is_jal) begin
            ctrl.rf_we  = 1'b1;
            ctrl.rf_dst = DST_RA;
            ctrl.rf_src = SRC_PC;
          end
        end
        EXEC: begin
          ctrl.aluout_we = !is_beq && !is_jr;
          ctrl.alu_b     = is_rtype ? B_REG : B_IMM;
          ctrl.alu_op    = is_rtype ? fn_op : (is_slti ? ALU_SLT : ALU_ADD);
          if (is_beq && a_eq_b) begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_ALUOUT;
          end
          if (is_jr) begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_A;
          end
        end
        MEM: begin
          ctrl.mem_req         = 1'b1;
          ctrl.mem_addr_aluout = 1'b1;
          ctrl.mem_we          = is_sw;
          ctrl.mdr_we          = mem_ack && is_lw;
        end
        WB: begin
          ctrl.rf_we  = 1'b1;
          ctrl.rf_dst = is_rtype ? DST_RD : DST_RT;
          ctrl.rf_src = is_lw ? SRC_MDR : SRC_ALUOUT;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (PCinit) begin
      state  <= FETCH;
      retire <= 1'b0;
      trap   <= 1'b0;
    end else begin
      retire <= 1'b0;
      if (bad) begin
        if (TRAP_ON_ILLEGAL) begin
          state <= TRAP;
          trap  <= 1'b1;
        end else begin
          state  <= FETCH;
          retire <= 1'b1;
        end
      end else begin
        case (state)
          FETCH: if (mem_ack) state <= DECODE;
          DECODE: begin
            if (is_j || is_jal) begin
              state  <= FETCH;
              retire <= 1'b1;
            end else begin
              state <= EXEC;
            end
          end
          EXEC: begin
            if (is_beq || is_jr) begin
              state  <= FETCH;
              retire <= 1'b1;
            end else if (is_lw || is_sw) begin
              state <= MEM;
            end else begin
              state <= WB;
            end
          end
          MEM: begin
            if (mem_ack) begin
              if (is_lw) begin
                state <= WB;
              end else begin
                state  <= FETCH;
                retire <= 1'b1;
              end
            end
          end
          WB: begin
            state  <= FETCH;
            retire <= 1'b1;
          end
          TRAP:    state <= TRAP;
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath over a single req/ack memory port; architectural
// registers and register file live here, sequencing lives in mc_control.
module multicycle_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              PCinit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              trap,
  output logic [31:0]       pc_dbg
);

  logic [31:0] pc, ir, a_q, b_q, aluout, mdr;
  logic [31:0] rf [32];
  logic [31:0] rs_val, rt_val, imm_sext, alu_a, alu_b, alu_y, pc_next, rf_wdata;
  logic [4:0]  rs, rt, rd, rf_waddr;
  ctrl_t       ctrl;

  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf[rt];

  mc_control #(
    .TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)
  ) u_control (
    .clk    (clk),
    .PCinit (PCinit),
    .op     (ir[31:26]),
    .fn     (ir[5:0]),
    .a_eq_b (a_q == b_q),
    .mem_ack(mem_ack),
    .ctrl   (ctrl),
    .retire (retire),
    .trap   (trap)
  );

  assign alu_a = ctrl.alu_a_pc ? pc : a_q;

  always_comb begin
    case (ctrl.alu_b)
      B_REG:   alu_b = b_q;
      B_FOUR:  alu_b = 32'd4;
      B_IMM:   alu_b = imm_sext;
      default: alu_b = imm_sext << 2;
    endcase
  end

  assign alu_y = alu(ctrl.alu_op, alu_a, alu_b);

  always_comb begin
    case (ctrl.pc_src)
      PC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      PC_ALUOUT: pc_next = aluout;
      PC_A:      pc_next = a_q;
      default:   pc_next = alu_y;
    endcase
  end

  always_comb begin
    case (ctrl.rf_dst)
      DST_RD:  rf_waddr = rd;
      DST_RT:  rf_waddr = rt;
      default: rf_waddr = 5'd31;
    endcase
    case (ctrl.rf_src)
      SRC_MDR: rf_wdata = mdr;
      SRC_PC:  rf_wdata = pc;
      default: rf_wdata = aluout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (PCinit) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      if (ctrl.pc_we)     pc     <= pc_next;
      if (ctrl.ir_we)     ir     <= mem_rdata;
      if (ctrl.aluout_we) aluout <= alu_y;
      if (ctrl.mdr_we)    mdr    <= mem_rdata;
      if (ctrl.ab_we) begin
        a_q <= rs_val;
        b_q <= rt_val;
      end
    end
  end

  // NOTE: the register file is a plain RAM with no reset; software initialises it.
  always_ff @(posedge clk) begin
    if (ctrl.rf_we && (rf_waddr != 5'd0)) rf[rf_waddr] <= rf_wdata;
  end

  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign mem_addr  = ctrl.mem_addr_aluout ? aluout[ADDR_W-1:0] : pc[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign pc_dbg    = pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed program run against a unified memory model with configurable data-access wait states.
module tb_multicycle_datapath;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        PCinit = 1'b1;
  logic        mem_req, mem_we, mem_ack, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  logic [31:0] mem [1024];
  logic        ack_m, late_ack = 1'b0;
  logic [31:0] rdata_m;
  logic [31:0] hold_addr = 32'hFFFF_FFFF;
  int          data_wait = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  multicycle_datapath dut (
    .clk      (clk),
    .PCinit   (PCinit),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .retire   (retire),
    .trap     (trap),
    .pc_dbg   (pc_dbg)
  );

  always #5 clk = ~clk;

  // Words at 0x10..0x1F are data and take data_wait extra cycles; everything else acks at once.
  assign ack_m = mem_req && (mem_addr != hold_addr) &&
                 (wait_cnt >= ((mem_addr[31:4] == 28'h1) ? data_wait : 0));
  assign rdata_m   = mem[mem_addr[11:2]];
  assign mem_ack   = ack_m | late_ack;
  assign mem_rdata = late_ack ? 32'h2004_0063 : rdata_m;

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic put(input logic [11:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask

  // Called on a negedge; runs until the next retire pulse. With watch set, the data
  // access occupies cycles 3..6 (3 wait states) and must hold its address/data steady.
  task automatic step(input string tag, input int exp_cyc, input logic [31:0] exp_pc,
                      input logic watch, input logic watch_we);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (watch && n >= 3 && n <= 6) begin
        check({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        check({tag, "_addr"}, mem_addr, 32'h10);
        check({tag, "_we"}, {31'b0, mem_we}, {31'b0, watch_we});
        if (watch_we) check({tag, "_wdata"}, mem_wdata, 32'd12);
      end
      seen = retire;
    end
    check({tag, "_retired"}, {31'b0, seen}, 32'd1);
    if (seen && exp_cyc >= 0) check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, "_pc"}, pc_dbg, exp_pc);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    put(12'h000, enc_i(ADDI, 0, 1, 16'd5));
    put(12'h004, enc_i(ADDI, 0, 2, 16'd7));
    put(12'h008, enc_r(ADD, 1, 2, 3));
    put(12'h00C, enc_j(J, 26'h20));
    put(12'h020, enc_i(BEQ, 1, 1, 16'd2));
    put(12'h02C, enc_i(BEQ, 1, 2, 16'd5));
    put(12'h030, enc_j(J, 26'h10));
    put(12'h040, enc_j(JAL, 26'h100));
    put(12'h044, enc_j(J, 26'h18));
    put(12'h060, enc_i(ADDI, 0, 5, 16'd3));
    put(12'h064, enc_i(ADDI, 0, 0, 16'd9));
    put(12'h068, enc_r(ADD, 0, 0, 5));
    put(12'h06C, enc_i(ADDI, 0, 6, 16'd1));
    put(12'h070, enc_i(SLTI, 1, 6, 16'hFFFF));
    put(12'h074, enc_i(SLTI, 1, 7, 16'd6));
    put(12'h078, 32'hFC00_0000);
    put(12'h080, enc_i(SW, 0, 3, 16'd16));
    put(12'h084, enc_i(LW, 0, 4, 16'd16));
    put(12'h088, enc_r(SUB, 1, 2, 8));
    put(12'h08C, enc_r(AND, 1, 2, 9));
    put(12'h090, enc_r(OR, 1, 2, 10));
    put(12'h094, enc_r(SLT, 8, 1, 11));
    put(12'h098, enc_j(J, 26'h08));
    put(12'h400, enc_r(JR, 31, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc_dbg, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_ir", dut.ir, 32'h0);
    PCinit = 1'b0;

    step("addi1", 4, 32'h04, 1'b0, 1'b0);
    check("r1", dut.rf[1], 32'd5);
    step("addi2", 4, 32'h08, 1'b0, 1'b0);
    check("r2", dut.rf[2], 32'd7);
    step("add", 4, 32'h0C, 1'b0, 1'b0);
    check("r3", dut.rf[3], 32'd12);
    step("j80", -1, 32'h80, 1'b0, 1'b0);

    data_wait = 3;
    step("sw", 7, 32'h84, 1'b1, 1'b1);
    check("mem10", mem[4], 32'd12);
    step("lw", 8, 32'h88, 1'b1, 1'b0);
    check("r4", dut.rf[4], 32'd12);
    data_wait = 0;

    step("sub", 4, 32'h8C, 1'b0, 1'b0);
    check("r8", dut.rf[8], 32'hFFFF_FFFE);
    step("and", 4, 32'h90, 1'b0, 1'b0);
    check("r9", dut.rf[9], 32'd5);
    step("or", 4, 32'h94, 1'b0, 1'b0);
    check("r10", dut.rf[10], 32'd7);
    step("slt", 4, 32'h98, 1'b0, 1'b0);
    check("r11", dut.rf[11], 32'd1);
    step("j20", -1, 32'h20, 1'b0, 1'b0);

    step("beq_t", 3, 32'h2C, 1'b0, 1'b0);
    step("beq_nt", 3, 32'h30, 1'b0, 1'b0);
    step("j40", -1, 32'h40, 1'b0, 1'b0);
    step("jal", -1, 32'h400, 1'b0, 1'b0);
    check("r31", dut.rf[31], 32'h44);
    step("jr", 3, 32'h44, 1'b0, 1'b0);
    step("j60", -1, 32'h60, 1'b0, 1'b0);

    step("addi5", 4, 32'h64, 1'b0, 1'b0);
    step("addi0", 4, 32'h68, 1'b0, 1'b0);
    step("add0", 4, 32'h6C, 1'b0, 1'b0);
    check("r5", dut.rf[5], 32'd0);
    step("addi6", 4, 32'h70, 1'b0, 1'b0);
    step("slti_neg", 4, 32'h74, 1'b0, 1'b0);
    check("r6", dut.rf[6], 32'd0);
    step("slti_pos", 4, 32'h78, 1'b0, 1'b0);
    check("r7", dut.rf[7], 32'd1);

    n = 0;
    while (!trap && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("trap_set", {31'b0, trap}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("trap_req", {31'b0, mem_req}, 32'd0);
      check("trap_hold", {31'b0, trap}, 32'd1);
    end

    hold_addr = 32'h4;
    PCinit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("trap_clr", {31'b0, trap}, 32'd0);
    check("trap_rst_pc", pc_dbg, 32'h0);
    PCinit = 1'b0;

    step("refetch", 4, 32'h04, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_req", {31'b0, mem_req}, 32'd1);
      check("stall_addr", mem_addr, 32'h4);
    end
    PCinit   = 1'b1;
    late_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_req", {31'b0, mem_req}, 32'd0);
    check("abort_pc", pc_dbg, 32'h0);
    check("abort_ir", dut.ir, 32'h0);
    check("abort_retire", {31'b0, retire}, 32'd0);
    PCinit    = 1'b0;
    late_ack  = 1'b0;
    hold_addr = 32'hFFFF_FFFF;
    step("restart", 4, 32'h04, 1'b0, 1'b0);
    check("restart_r1", dut.rf[1], 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
